arb_mux: RTL
============

# arb_mux

Packet-aware round-robin arbitrated multiplexer. It collects W valid/ready request channels, uses an `rr` instance to pick a winner, and locks onto that winner until its packet's last beat. The chosen beat goes into a single registered output stage. It sits directly downstream of the per-requestor queues and upstream of any shared egress port (bus, NoC link, shared pipeline).

## Interface
Parameters:
- `W`, 4: number of requestor channels; W ≥ 2, power of two.
- `DATA_W`, 32: payload width per beat.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  W  per-channel beat valid.
- `i_last`  in  W  per-channel last-beat-of-packet flag; qualified by `i_valid`.
- `i_data`  in  W×DATA_W  per-channel payload; channel k occupies bits [k·DATA_W +: DATA_W].
- `o_ready_in`  out  W  per-channel accept; beat on channel k transfers when `i_valid[k] & o_ready_in[k]`.
- `o_valid`  out  1  output beat valid (registered).
- `o_last`  out  1  output last flag (registered).
- `o_data`  out  DATA_W  output payload (registered).
- `o_src`  out  $clog2(W)  source channel index of the output beat (registered).
- `i_ready`  in  1  downstream accept; transfer when `o_valid & i_ready`.
- `o_busy`  out  1  high while a packet is locked (state LOCKED).

## Operation
State machine with two states, IDLE and LOCKED, plus lock register `lock_idx`.

Stage free:
- `adv = ~o_valid | i_ready`.

IDLE:
- The `rr` request vector is `i_valid`; its one-hot grant selects a candidate.
- `o_ready_in` is the grant ANDed with `adv`.
- On a transfer from granted channel g, `rr` is acked (pointer moves to g+1 mod W), and the beat is loaded into the output register.
- If `i_last[g]` is 0, capture `lock_idx = g` and go to LOCKED.
- If `i_last[g]` is 1, stay in IDLE (single-beat packet).

LOCKED:
- Only `o_ready_in[lock_idx]` may assert, equal to `adv`.
- Other channels are stalled regardless of `i_valid`.
- `rr` is not acked, so its pointer is frozen.
- When a beat with `i_last` = 1 transfers, return to IDLE.
- A bubble (`i_valid[lock_idx]` = 0) holds LOCKED indefinitely.

Output register:
- Loaded when `adv` and any channel transfers.
- `o_valid` clears when `i_ready & o_valid` and nothing is loaded that cycle.
- Payload, last and src hold their value while `o_valid & ~i_ready` (no change while stalled).

Reset values:
- `o_valid` = 0, `o_last` = 0, `o_data` = 0, `o_src` = 0, `o_busy` = 0.
- State = IDLE; `rr` pointer = 0, so channel 0 has top priority.

Boundary conditions:
- Simultaneous downstream drain and new load: the new beat replaces the old one in the same cycle, giving full throughput.
- Pointer wrap: a grant to W-1 moves the pointer to 0.
- `rst` asserted mid-packet: the lock is abandoned and the partial output beat is dropped. Upstream must also reset.
- `o_ready_in` never asserts on more than one channel per cycle.

## Timing
- Latency: a beat accepted at edge t appears on `o_*` after edge t (visible cycle t+1).
- Throughput: 1 beat/cycle while `i_ready` stays high.
- `o_ready_in` depends combinationally on `i_valid`, `i_ready` and state. There is no path from `i_data` to any output. `o_*` are pure flop outputs.
- Arbitration decision and grant occur in the same cycle as request presentation; there is no request-to-grant bubble.
- After a LOCKED→IDLE transition, a new winner can transfer in the very next cycle.

## Structure
- Shared package `arb_pkg`: state enum `arb_mux_state_t` {IDLE, LOCKED}.
- Sub-module: one `rr #(.W(W))` instance for arbitration. The one-hot grant is encoded locally for `o_src`/`lock_idx`.
- Everything else is local: FSM, lock register, payload mux, output register.

## Test plan
- Reset then idle: `o_valid` = 0 and `o_ready_in` = 0. Next, `i_valid` = 4'b1111 single-beat on all channels with `i_ready` = 1 → `o_src` sequence 0, 1, 2, 3, 0, with one beat per cycle.
- Multi-beat lock: ch2 sends 3 beats (last on the 3rd) while ch0 and ch1 are valid → `o_src` = 2, 2, 2, then 3-beat packet boundary honoured, next grant = 3 if valid, else 0. `o_busy` is high for exactly 2 cycles.
- Backpressure: `i_ready` = 0 for 5 cycles with output holding `o_data` = 0xA5 → `o_data`, `o_last` and `o_src` are stable, `o_valid` = 1, and all `o_ready_in` = 0. When `i_ready` rises, the next beat loads in that same cycle.
- Bubble inside a packet: ch1 beat 1, then `i_valid[1]` = 0 for 3 cycles, then the last beat, while ch3 is valid throughout → ch3 is never granted until ch1's last beat transfers.
- Wrap and fairness: ch3 granted, then ch0 and ch3 both valid → ch0 wins. Over 100 random cycles, per-channel grant counts differ by at most 1 under full load.
- Reset mid-packet: assert `rst` while LOCKED on ch1 → the next cycle shows `o_valid` = 0 and `o_busy` = 0, and with all channels valid the first grant is ch0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the packet-aware arbitrated multiplexer.
package arb_pkg;

    // IDLE: arbitrating among requestors; LOCKED: following one packet to its last beat.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_mux_state_t;

endpackage : arb_pkg

// File: rtl/rr.sv
// Round-robin arbiter: one-hot grant from a rotating priority pointer.
// The grant is combinational from req; the pointer only advances on ack.
module rr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req,
    input  logic         ack,
    output logic [W-1:0] gnt
);

    localparam int IW = $clog2(W);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;
    logic          found;

    // Scan from the pointer upward, wrapping naturally because W is a power of two.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < W; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

    // Pointer moves to one past the acknowledged winner; W-1 wraps to 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            ptr <= '0;
        end else if (ack && found) begin
            ptr <= gnt_idx + IW'(1);
        end
    end

endmodule : rr

// File: rtl/arb_mux.sv
// Packet-aware round-robin arbitrated mux with a single registered output stage.
// A multi-beat packet locks the mux onto its source until the last beat passes.
module arb_mux
    import arb_pkg::*;
#(
    parameter int W      = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           i_valid,
    input  logic [W-1:0]           i_last,
    input  logic [W*DATA_W-1:0]    i_data,
    output logic [W-1:0]           o_ready_in,
    output logic                   o_valid,
    output logic                   o_last,
    output logic [DATA_W-1:0]      o_data,
    output logic [$clog2(W)-1:0]   o_src,
    input  logic                   i_ready,
    output logic                   o_busy
);

    localparam int IW = $clog2(W);

    arb_mux_state_t state;
    logic [IW-1:0]  lock_idx;
    logic [W-1:0]   gnt;
    logic [IW-1:0]  gnt_idx;
    logic [IW-1:0]  sel_idx;
    logic           adv;
    logic           xfer;
    logic           sel_last;
    logic           rr_ack;

    // Output stage can take a new beat when empty or draining this cycle.
    assign adv = ~o_valid | i_ready;

    rr #(.W(W)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (i_valid),
        .ack (rr_ack),
        .gnt (gnt)
    );

    // Encode the one-hot grant to a channel index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (gnt[i]) gnt_idx = IW'(i);
        end
    end

    // Accept steering: the arbiter winner while idle, only the locked channel otherwise.
    always_comb begin
        o_ready_in = '0;
        if (state == IDLE) begin
            o_ready_in = gnt & {W{adv}};
        end else begin
            o_ready_in[lock_idx] = adv;
        end
    end

    assign xfer     = |(i_valid & o_ready_in);
    assign sel_idx  = (state == IDLE) ? gnt_idx : lock_idx;
    assign sel_last = i_last[sel_idx];
    assign rr_ack   = (state == IDLE) && xfer;
    assign o_busy   = (state == LOCKED);

    // Lock FSM: enter LOCKED on a non-last beat, leave on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer && !sel_last) begin
                        state    <= LOCKED;
                        lock_idx <= sel_idx;
                    end
                end
                LOCKED: begin
                    if (xfer && sel_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on transfer, drain on downstream accept, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
            o_src   <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_last  <= sel_last;
            o_data  <= i_data[sel_idx*DATA_W +: DATA_W];
            o_src   <= sel_idx;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule : arb_mux
